// File: rtl/fp_pkg.sv
// Shared definitions for the FPU arithmetic units: rounding modes, sequencer
// states, derived widths and constant encodings for NaN / inf / max finite.
package fp_pkg;

  localparam int unsigned EXP_W_DEF = 8;
  localparam int unsigned MAN_W_DEF = 23;
  // Constant encodings are built in a wide vector and sliced by the user.
  localparam int unsigned WIDE_W = 128;

  typedef enum logic [1:0] {
    RND_RNE = 2'b00,
    RND_RTZ = 2'b01,
    RND_RUP = 2'b10,
    RND_RDN = 2'b11
  } round_mode_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_UNPACK = 3'd1,
    S_ALIGN  = 3'd2,
    S_ADD    = 3'd3,
    S_NORM   = 3'd4,
    S_ROUND  = 3'd5
  } state_e;

  function automatic int unsigned fp_word_w(input int unsigned exp_w, input int unsigned man_w);
    return 1 + exp_w + man_w;
  endfunction

  // hidden + mantissa + guard, round, sticky
  function automatic int unsigned fp_sig_w(input int unsigned man_w);
    return man_w + 4;
  endfunction

  // Signed working exponent: must hold max exponent + 2 and go below zero
  // by a full significand's worth of leading zeros.
  function automatic int unsigned fp_xexp_w(input int unsigned exp_w, input int unsigned man_w);
    return exp_w + $clog2(man_w + 5) + 1;
  endfunction

  function automatic logic [WIDE_W-1:0] fp_exp_ones(input int unsigned exp_w, input int unsigned man_w);
    return ((WIDE_W'(1) << exp_w) - WIDE_W'(1)) << man_w;
  endfunction

  function automatic logic [WIDE_W-1:0] fp_canon_nan(input int unsigned exp_w, input int unsigned man_w);
    return fp_exp_ones(exp_w, man_w) | (WIDE_W'(1) << (man_w - 1));
  endfunction

  function automatic logic [WIDE_W-1:0] fp_inf(input logic sign, input int unsigned exp_w,
                                              input int unsigned man_w);
    return fp_exp_ones(exp_w, man_w) | (WIDE_W'(sign) << (exp_w + man_w));
  endfunction

  function automatic logic [WIDE_W-1:0] fp_max_finite(input logic sign, input int unsigned exp_w,
                                                     input int unsigned man_w);
    return (((WIDE_W'(1) << (exp_w + man_w)) - WIDE_W'(1)) & ~(WIDE_W'(1) << man_w))
           | (WIDE_W'(sign) << (exp_w + man_w));
  endfunction

  // Leading zeros of v[width-1:0]; returns width when the field is all zero.
  function automatic int unsigned fp_lzc(input logic [WIDE_W-1:0] v, input int unsigned width);
    int unsigned n;
    logic found;
    n = 0;
    found = 1'b0;
    for (int i = WIDE_W - 1; i >= 0; i--) begin
      if ((i < int'(width)) && !found) begin
        if (v[i]) found = 1'b1;
        else n++;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/fp_round.sv
// Combinational rounding back end: round-increment decision from G/R/S,
// renormalisation on mantissa carry, overflow saturation and underflow flush.
module fp_round
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = EXP_W_DEF,
  parameter int unsigned MAN_W = MAN_W_DEF,
  parameter int unsigned XE_W  = fp_xexp_w(EXP_W_DEF, MAN_W_DEF)
) (
  input  logic                    sign,
  input  logic signed [XE_W-1:0]  exp_in,
  input  logic [MAN_W+3:0]        sig,
  input  round_mode_e             mode,
  output logic [EXP_W+MAN_W:0]    y,
  output logic                    overflow,
  output logic                    underflow,
  output logic                    inexact
);

  localparam logic [WIDE_W-1:0] INF_WIDE = fp_inf(1'b0, EXP_W, MAN_W);
  localparam logic [WIDE_W-1:0] MAX_WIDE = fp_max_finite(1'b0, EXP_W, MAN_W);
  localparam logic [EXP_W+MAN_W-1:0] INF_MAG = INF_WIDE[EXP_W+MAN_W-1:0];
  localparam logic [EXP_W+MAN_W-1:0] MAX_MAG = MAX_WIDE[EXP_W+MAN_W-1:0];
  localparam logic signed [XE_W-1:0] EXP_OVF = XE_W'((2 ** EXP_W) - 1);

  logic                   lost;
  logic                   up;
  logic [MAN_W+1:0]       mant;
  logic                   carry;
  logic [MAN_W-1:0]       frac;
  logic signed [XE_W-1:0] exp_f;
  logic                   to_inf;

  // Round, renormalise and saturate to the mode-specific overflow value
  always_comb begin
    lost = sig[2] | sig[1] | sig[0];
    up   = 1'b0;
    case (mode)
      RND_RNE: up = sig[2] & (sig[1] | sig[0] | sig[3]);
      RND_RTZ: up = 1'b0;
      RND_RUP: up = ~sign & lost;
      RND_RDN: up = sign & lost;
      default: up = 1'b0;
    endcase
    mant  = {1'b0, sig[MAN_W+3:3]} + {{(MAN_W+1){1'b0}}, up};
    carry = mant[MAN_W+1];
    frac  = carry ? mant[MAN_W:1] : mant[MAN_W-1:0];
    exp_f = carry ? exp_in + XE_W'(1) : exp_in;
    to_inf = (mode == RND_RNE) | ((mode == RND_RUP) & ~sign) | ((mode == RND_RDN) & sign);
    overflow  = (exp_f >= EXP_OVF);
    underflow = !overflow && (exp_f[XE_W-1] || (exp_f == '0));
    inexact   = lost | overflow | underflow;
    if (overflow) y = {sign, to_inf ? INF_MAG : MAX_MAG};
    else if (underflow) y = {sign, {(EXP_W+MAN_W){1'b0}}};
    else y = {sign, exp_f[EXP_W-1:0], frac};
  end

endmodule

// File: rtl/fp_addsub_seq.sv
// Multi-cycle floating-point adder/subtractor, fixed 5-cycle latency from
// the Start edge to Done, one pipeline step per FSM state.
//
// state  | meaning
// IDLE   | waiting for start; operands captured on start
// UNPACK | split fields, flush denormals, classify NaN/inf specials
// ALIGN  | order by magnitude, right-shift smaller with sticky
// ADD    | add/subtract significands by effective sign
// NORM   | carry right-shift or leading-zero left-shift
// ROUND  | round/pack or select special result; raises done
module fp_addsub_seq
  import fp_pkg::*;
#(
  parameter int unsigned EXP_W = EXP_W_DEF,
  parameter int unsigned MAN_W = MAN_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 op,
  input  logic [1:0]           round,
  input  logic [EXP_W+MAN_W:0] a,
  input  logic [EXP_W+MAN_W:0] b,
  output logic                 busy,
  output logic                 done,
  output logic [EXP_W+MAN_W:0] y,
  output logic                 overflow,
  output logic                 underflow,
  output logic                 invalid,
  output logic                 inexact
);

  localparam int unsigned W     = fp_word_w(EXP_W, MAN_W);
  localparam int unsigned SIG_W = fp_sig_w(MAN_W);
  localparam int unsigned SUM_W = SIG_W + 1;
  localparam int unsigned XE_W  = fp_xexp_w(EXP_W, MAN_W);
  localparam logic [EXP_W-1:0]  EXP_MAX  = '1;
  localparam logic [WIDE_W-1:0] NAN_WIDE = fp_canon_nan(EXP_W, MAN_W);
  localparam logic [W-1:0]      NAN_Y    = NAN_WIDE[W-1:0];

  state_e state_q, state_d;
  logic [W-1:0] a_q, a_d, b_q, b_d;
  logic op_q, op_d;
  round_mode_e rnd_q, rnd_d;
  logic sa_q, sa_d, sb_q, sb_d;
  logic [EXP_W-1:0] ea_q, ea_d, eb_q, eb_d;
  logic [MAN_W:0] ma_q, ma_d, mb_q, mb_d;
  logic spec_q, spec_d, spec_inv_q, spec_inv_d;
  logic [W-1:0] spec_y_q, spec_y_d;
  logic [SIG_W-1:0] big_q, big_d, sml_q, sml_d, norm_q, norm_d;
  logic signed [XE_W-1:0] exp_q, exp_d;
  logic sign_q, sign_d, sub_q, sub_d, zero_q, zero_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [W-1:0] y_q, y_d;
  logic ovf_q, ovf_d, unf_q, unf_d, inv_q, inv_d, inx_q, inx_d, done_q, done_d;

  // unpack stage signals
  logic ua_sign, ub_sign, ua_zero, ub_zero, ua_inf, ub_inf, ua_nan, ub_nan, us_inv;
  logic [EXP_W-1:0] ua_exp, ub_exp;
  logic [MAN_W:0] ua_sig, ub_sig;
  logic [W-1:0] us_y;
  // align stage signals
  logic al_a_big;
  logic [EXP_W-1:0] al_e_big, al_e_sml, al_diff;
  logic [SIG_W-1:0] al_big, al_sml_raw, al_mask, al_sml;
  logic al_sticky;
  int unsigned al_sh;
  // normalise stage signals
  int unsigned nm_lz;
  logic [SIG_W-1:0] nm_sig;
  logic signed [XE_W-1:0] nm_exp;
  // round stage signals
  logic [W-1:0] rd_y;
  logic rd_ovf, rd_unf, rd_inx;

  // Field split, denormal flush and special-operand classification
  always_comb begin
    ua_sign = a_q[W-1];
    ub_sign = b_q[W-1] ^ op_q;
    ua_exp  = a_q[W-2 -: EXP_W];
    ub_exp  = b_q[W-2 -: EXP_W];
    ua_zero = (ua_exp == '0);
    ub_zero = (ub_exp == '0);
    ua_inf  = (ua_exp == EXP_MAX) && (a_q[MAN_W-1:0] == '0);
    ub_inf  = (ub_exp == EXP_MAX) && (b_q[MAN_W-1:0] == '0);
    ua_nan  = (ua_exp == EXP_MAX) && (a_q[MAN_W-1:0] != '0);
    ub_nan  = (ub_exp == EXP_MAX) && (b_q[MAN_W-1:0] != '0);
    ua_sig  = ua_zero ? '0 : {1'b1, a_q[MAN_W-1:0]};
    ub_sig  = ub_zero ? '0 : {1'b1, b_q[MAN_W-1:0]};
    us_inv  = ua_nan | ub_nan | (ua_inf & ub_inf & (ua_sign != ub_sign));
    if (us_inv) us_y = NAN_Y;
    else if (ua_inf) us_y = {ua_sign, EXP_MAX, {MAN_W{1'b0}}};
    else us_y = {ub_sign, EXP_MAX, {MAN_W{1'b0}}};
  end

  // Magnitude ordering and sticky-preserving alignment shift
  always_comb begin
    al_a_big   = {ea_q, ma_q} >= {eb_q, mb_q};
    al_e_big   = al_a_big ? ea_q : eb_q;
    al_e_sml   = al_a_big ? eb_q : ea_q;
    al_big     = {al_a_big ? ma_q : mb_q, 3'b000};
    al_sml_raw = {al_a_big ? mb_q : ma_q, 3'b000};
    al_diff    = al_e_big - al_e_sml;
    al_sh      = (32'(al_diff) > SIG_W - 1) ? SIG_W - 1 : 32'(al_diff);
    al_mask    = ~({SIG_W{1'b1}} << al_sh);
    al_sticky  = |(al_sml_raw & al_mask);
    al_sml     = (al_sml_raw >> al_sh) | {{(SIG_W-1){1'b0}}, al_sticky};
  end

  // Normalisation of the raw sum
  always_comb begin
    nm_lz = fp_lzc(WIDE_W'(sum_q[SIG_W-1:0]), SIG_W);
    if (sum_q[SUM_W-1]) begin
      nm_sig = {sum_q[SUM_W-1:2], sum_q[1] | sum_q[0]};
      nm_exp = exp_q + XE_W'(1);
    end else begin
      nm_sig = sum_q[SIG_W-1:0] << nm_lz;
      nm_exp = exp_q - XE_W'(nm_lz);
    end
  end

  fp_round #(.EXP_W(EXP_W), .MAN_W(MAN_W), .XE_W(XE_W)) u_round (
    .sign      (sign_q),
    .exp_in    (exp_q),
    .sig       (norm_q),
    .mode      (rnd_q),
    .y         (rd_y),
    .overflow  (rd_ovf),
    .underflow (rd_unf),
    .inexact   (rd_inx)
  );

  // Sequencer: next state and per-stage register updates
  always_comb begin
    state_d = state_q;
    a_d = a_q; b_d = b_q; op_d = op_q; rnd_d = rnd_q;
    sa_d = sa_q; sb_d = sb_q; ea_d = ea_q; eb_d = eb_q; ma_d = ma_q; mb_d = mb_q;
    spec_d = spec_q; spec_inv_d = spec_inv_q; spec_y_d = spec_y_q;
    big_d = big_q; sml_d = sml_q; exp_d = exp_q; sign_d = sign_q; sub_d = sub_q;
    sum_d = sum_q; norm_d = norm_q; zero_d = zero_q;
    y_d = y_q; ovf_d = ovf_q; unf_d = unf_q; inv_d = inv_q; inx_d = inx_q;
    done_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_d = a; b_d = b; op_d = op; rnd_d = round_mode_e'(round);
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        sa_d = ua_sign; sb_d = ub_sign; ea_d = ua_exp; eb_d = ub_exp;
        ma_d = ua_sig; mb_d = ub_sig;
        spec_d = ua_nan | ub_nan | ua_inf | ub_inf;
        spec_inv_d = us_inv;
        spec_y_d = us_y;
        state_d = S_ALIGN;
      end
      S_ALIGN: begin
        big_d  = al_big;
        sml_d  = al_sml;
        exp_d  = XE_W'(al_e_big);
        sign_d = al_a_big ? sa_q : sb_q;
        sub_d  = sa_q ^ sb_q;
        state_d = S_ADD;
      end
      S_ADD: begin
        sum_d = sub_q ? ({1'b0, big_q} - {1'b0, sml_q}) : ({1'b0, big_q} + {1'b0, sml_q});
        state_d = S_NORM;
      end
      S_NORM: begin
        norm_d = nm_sig;
        exp_d  = nm_exp;
        zero_d = (sum_q == '0);
        state_d = S_ROUND;
      end
      S_ROUND: begin
        done_d = 1'b1;
        state_d = S_IDLE;
        if (spec_q) begin
          y_d = spec_y_q; ovf_d = 1'b0; unf_d = 1'b0; inv_d = spec_inv_q; inx_d = 1'b0;
        end else if (zero_q) begin
          // Same-sign zeros keep their sign; true cancellation is +0 unless rounding down.
          y_d = {sub_q ? (rnd_q == RND_RDN) : sign_q, {(W-1){1'b0}}};
          ovf_d = 1'b0; unf_d = 1'b0; inv_d = 1'b0; inx_d = 1'b0;
        end else begin
          y_d = rd_y; ovf_d = rd_ovf; unf_d = rd_unf; inv_d = 1'b0; inx_d = rd_inx;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q <= '0; b_q <= '0; op_q <= 1'b0; rnd_q <= RND_RNE;
      sa_q <= 1'b0; sb_q <= 1'b0; ea_q <= '0; eb_q <= '0; ma_q <= '0; mb_q <= '0;
      spec_q <= 1'b0; spec_inv_q <= 1'b0; spec_y_q <= '0;
      big_q <= '0; sml_q <= '0; exp_q <= '0; sign_q <= 1'b0; sub_q <= 1'b0;
      sum_q <= '0; norm_q <= '0; zero_q <= 1'b0;
      y_q <= '0; ovf_q <= 1'b0; unf_q <= 1'b0; inv_q <= 1'b0; inx_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q <= a_d; b_q <= b_d; op_q <= op_d; rnd_q <= rnd_d;
      sa_q <= sa_d; sb_q <= sb_d; ea_q <= ea_d; eb_q <= eb_d; ma_q <= ma_d; mb_q <= mb_d;
      spec_q <= spec_d; spec_inv_q <= spec_inv_d; spec_y_q <= spec_y_d;
      big_q <= big_d; sml_q <= sml_d; exp_q <= exp_d; sign_q <= sign_d; sub_q <= sub_d;
      sum_q <= sum_d; norm_q <= norm_d; zero_q <= zero_d;
      y_q <= y_d; ovf_q <= ovf_d; unf_q <= unf_d; inv_q <= inv_d; inx_q <= inx_d;
      done_q <= done_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign y         = y_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign invalid   = inv_q;
  assign inexact   = inx_q;

endmodule

// File: tb/tb_fp_addsub_seq.sv
// Scoreboard bench for fp_addsub_seq: single precision and a 5/10 half-size
// instance. Stimulus pushes the expected result and done cycle; monitors pop
// and compare whenever done is seen.
module tb_fp_addsub_seq;

  typedef struct {
    logic [31:0] y;
    logic [3:0]  f;   // {overflow, underflow, invalid, inexact}
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        start = 1'b0, op = 1'b0;
  logic [1:0]  rnd = 2'b00;
  logic [31:0] a = '0, b = '0, y;
  logic        busy, done, ovf, unf, inv, inx;

  logic        start_h = 1'b0, op_h = 1'b0;
  logic [1:0]  rnd_h = 2'b00;
  logic [15:0] a_h = '0, b_h = '0, y_h;
  logic        busy_h, done_h, ovf_h, unf_h, inv_h, inx_h;

  exp_t q_s[$];
  exp_t q_h[$];
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  fp_addsub_seq #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .round(rnd), .a(a), .b(b),
    .busy(busy), .done(done), .y(y), .overflow(ovf), .underflow(unf),
    .invalid(inv), .inexact(inx)
  );

  fp_addsub_seq #(.EXP_W(5), .MAN_W(10)) dut_h (
    .clk(clk), .rst(rst), .start(start_h), .op(op_h), .round(rnd_h), .a(a_h), .b(b_h),
    .busy(busy_h), .done(done_h), .y(y_h), .overflow(ovf_h), .underflow(unf_h),
    .invalid(inv_h), .inexact(inx_h)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : mon_sp
    exp_t e;
    if (done === 1'b1) begin
      if (q_s.size() == 0) begin
        checks++; errors++;
        $display("FAIL sp_spurious_done: done with nothing outstanding, y=%h", y);
      end else begin
        e = q_s.pop_front();
        check("sp_y", y, e.y);
        check("sp_flags", {28'd0, ovf, unf, inv, inx}, {28'd0, e.f});
        check("sp_done_cycle", cyc, e.cyc);
        check("sp_busy_in_done", {31'd0, busy}, 32'd0);
      end
    end
  end

  always @(negedge clk) begin : mon_hp
    exp_t e;
    if (done_h === 1'b1) begin
      if (q_h.size() == 0) begin
        checks++; errors++;
        $display("FAIL hp_spurious_done: done with nothing outstanding, y=%h", y_h);
      end else begin
        e = q_h.pop_front();
        check("hp_y", {16'd0, y_h}, e.y);
        check("hp_flags", {28'd0, ovf_h, unf_h, inv_h, inx_h}, {28'd0, e.f});
        check("hp_done_cycle", cyc, e.cyc);
      end
    end
  end

  // Issue one single-precision op; returns so that the next issue lands in the done cycle.
  task automatic issue(input logic [31:0] av, input logic [31:0] bv, input logic opv,
                       input logic [1:0] rm, input logic [31:0] ey, input logic [3:0] ef);
    @(negedge clk);
    a = av; b = bv; op = opv; rnd = rm; start = 1'b1;
    @(posedge clk); #1;
    q_s.push_back('{y: ey, f: ef, cyc: cyc + 5});
    start = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic issue_h(input logic [15:0] av, input logic [15:0] bv, input logic opv,
                         input logic [1:0] rm, input logic [15:0] ey, input logic [3:0] ef);
    @(negedge clk);
    a_h = av; b_h = bv; op_h = opv; rnd_h = rm; start_h = 1'b1;
    @(posedge clk); #1;
    q_h.push_back('{y: {16'd0, ey}, f: ef, cyc: cyc + 5});
    start_h = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_y", y, 32'd0);
    check("reset_flags", {28'd0, ovf, unf, inv, inx}, 32'd0);
    rst = 1'b0;

    // basic add and a mixed-sign subtract
    issue(32'h43700000, 32'h42F00000, 1'b0, 2'b00, 32'h43B40000, 4'b0000);
    issue(32'hC3700000, 32'h42F00000, 1'b0, 2'b00, 32'hC2F00000, 4'b0000);
    // halfway tie in each mode, then above-half
    issue(32'h3F800000, 32'h33800000, 1'b0, 2'b00, 32'h3F800000, 4'b0001);
    issue(32'h3F800000, 32'h33800000, 1'b0, 2'b01, 32'h3F800000, 4'b0001);
    issue(32'h3F800000, 32'h33800000, 1'b0, 2'b10, 32'h3F800001, 4'b0001);
    issue(32'h3F800000, 32'h33800000, 1'b0, 2'b11, 32'h3F800000, 4'b0001);
    issue(32'h3F800000, 32'h33C00000, 1'b0, 2'b00, 32'h3F800001, 4'b0001);
    // overflow per mode
    issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'b00, 32'h7F800000, 4'b1001);
    issue(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 2'b01, 32'h7F7FFFFF, 4'b1001);
    issue(32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 2'b10, 32'hFF7FFFFF, 4'b1001);
    issue(32'hFF7FFFFF, 32'hFF7FFFFF, 1'b0, 2'b11, 32'hFF800000, 4'b1001);
    // specials
    issue(32'h7F800000, 32'h7F800000, 1'b1, 2'b00, 32'h7FC00000, 4'b0010);
    issue(32'h7F800000, 32'hFF800000, 1'b0, 2'b00, 32'h7FC00000, 4'b0010);
    issue(32'h00000000, 32'h7F800000, 1'b0, 2'b00, 32'h7F800000, 4'b0000);
    issue(32'h7FC00001, 32'h3F800000, 1'b0, 2'b00, 32'h7FC00000, 4'b0010);
    // cancellation and signed zeros
    issue(32'h43700000, 32'h43700000, 1'b1, 2'b00, 32'h00000000, 4'b0000);
    issue(32'h43700000, 32'h43700000, 1'b1, 2'b11, 32'h80000000, 4'b0000);
    issue(32'h80000000, 32'h80000000, 1'b0, 2'b00, 32'h80000000, 4'b0000);
    // underflow and denormal flush
    issue(32'h00800001, 32'h00800000, 1'b1, 2'b00, 32'h00000000, 4'b0101);
    issue(32'h00000001, 32'h3F800000, 1'b0, 2'b00, 32'h3F800000, 4'b0000);

    // start re-pulsed while busy must be ignored
    @(negedge clk);
    a = 32'h43700000; b = 32'h42F00000; op = 1'b0; rnd = 2'b00; start = 1'b1;
    @(posedge clk); #1;
    q_s.push_back('{y: 32'h43B40000, f: 4'b0000, cyc: cyc + 5});
    start = 1'b0;
    @(negedge clk);
    a = 32'h3F800000; b = 32'h3F800000; start = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("busy_mid_op", {31'd0, busy}, 32'd1);
    start = 1'b0;
    repeat (10) @(negedge clk);

    // reset three cycles into an operation
    a = 32'h43700000; b = 32'h42F00000; op = 1'b0; rnd = 2'b00; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_y", y, 32'd0);
    check("abort_flags", {28'd0, ovf, unf, inv, inx}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    issue(32'h43700000, 32'h42F00000, 1'b0, 2'b00, 32'h43B40000, 4'b0000);

    // half-size instance
    issue_h(16'h3C00, 16'h3C00, 1'b0, 2'b00, 16'h4000, 4'b0000);
    issue_h(16'h3C00, 16'h3C00, 1'b1, 2'b11, 16'h8000, 4'b0000);
    issue_h(16'h7BFF, 16'h7BFF, 1'b0, 2'b00, 16'h7C00, 4'b1001);

    repeat (10) @(negedge clk);
    check("sp_queue_drained", q_s.size(), 32'd0);
    check("hp_queue_drained", q_h.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_addsub_seq.md
# fp_addsub_seq

Parametrised multi-cycle IEEE-754-style floating-point adder/subtractor with a start/done handshake, four rounding modes and separate exception flags. It is the successor to the fixed-format single-precision FPU add path. It is generic in exponent and mantissa width, and it reports results with a fixed latency so scoreboards can predict when each result arrives. It sits beside the multiply/divide units behind the FPU operation decoder.

## Interface
- EXP_W, 8, exponent field width (≥3)
- MAN_W, 23, stored mantissa width (≥2); word width W = 1+EXP_W+MAN_W
- Clock  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- Start  in  1  request; sampled only in IDLE
- Op  in  1  0 = A+B, 1 = A−B
- Round  in  2  00 nearest-even, 01 toward zero, 10 toward +inf, 11 toward −inf
- A, B  in  W  operands {sign, exponent, mantissa}
- Busy  out  1  high while an operation is in flight
- Done  out  1  one-cycle pulse; Y and flags are valid in this cycle and held afterwards
- Y  out  W  result
- Overflow, Underflow, Invalid, Inexact  out  1 each  exception flags, valid with Done

## Operation
- The FSM runs IDLE → UNPACK → ALIGN → ADD → NORM → ROUND → IDLE.
- On the Start edge in IDLE, the block captures A, B, Op and Round. Inputs are ignored afterwards.
- Start while Busy is ignored and is not queued.
- UNPACK:
  - Exponent 0 is treated as zero; denormals are flushed to zero on input.
  - B's sign is inverted when Op=1.
  - The hidden bit is prepended.
  - Special cases are classified here.
- ALIGN:
  - The smaller-magnitude operand is right-shifted by the exponent difference, saturated at MAN_W+3.
  - Significand datapath is MAN_W+4 bits (hidden + mantissa + guard, round, sticky), plus 1 carry bit.
  - Shifted-out bits are ORed into sticky.
- ADD: add or subtract by effective sign. The result sign is the sign of the larger magnitude.
- NORM:
  - On carry out, shift right by 1 (with sticky) and increment the exponent.
  - Otherwise, left-shift by the leading-zero count and decrement the exponent.
- ROUND:
  - Increment per mode using G/R/S and sign. RNE ties go to even.
  - A mantissa carry out of rounding renormalises.
  - Inexact = G|R|S ≠ 0.
- Exact cancellation gives +0, except Round=11, which gives −0. Zero plus zero of the same sign keeps that sign.
- Overflow (final biased exponent ≥ 2^EXP_W−1): Overflow=1, Inexact=1. The result depends on the mode:
  - RNE: ±inf.
  - RTZ: ±max finite.
  - Toward +inf: +inf if positive, −max finite if negative.
  - Toward −inf: −inf if negative, +max finite if positive.
- Underflow (biased exponent ≤ 0 before packing): result is signed zero, Underflow=1, Inexact=1.
- Specials:
  - Any NaN input gives canonical NaN {0, all-ones, 1, 0…}, Invalid=1.
  - inf − inf (effective) gives canonical NaN, Invalid=1.
  - inf ± finite gives that inf, no flags.
- Special results bypass the arithmetic but keep the same latency.

## Timing
- Reset values: state IDLE, Busy=0, Done=0, Y=0, all flags 0. Reset mid-operation aborts immediately and no Done follows.
- Start sampled at edge t gives Busy=1 from t through t+4. Done=1 after edge t+5 for exactly one cycle, with Busy=0.
- Fixed latency of 5 cycles for every operand class.
- Start may be high in the Done cycle; it is accepted at t+6. Initiation interval is 6 cycles.
- Y and flags change only at the edge that raises Done.

## Structure
- Shared package fp_pkg holds:
  - the rounding-mode enum, the FSM state enum
  - the width localparams derived from EXP_W and MAN_W
  - canonical-NaN, inf and max-finite constant functions
- Sub-module fp_round (combinational): increment decision, renormalise, overflow saturation per mode, Inexact. It is reusable by the multiply/divide units.
- Leading-zero counter is a function in fp_pkg.

## Test plan
- **Basic add:** A=0x43700000 (240), B=0x42F00000 (120), Op=0, Round=00 → Y=0x43B40000 (360), all flags 0, Done exactly 5 cycles after Start.
- **Round modes, tie:** A=0x3F800000, B=0x33800000 (tie), Op=0.
  - Round=00 → 0x3F800000; 01 → 0x3F800000; 10 → 0x3F800001; 11 → 0x3F800000. Inexact=1 in all.
  - B=0x33C00000 with Round=00 → 0x3F800001.
- **Overflow:** A=B=0x7F7FFFFF, Op=0.
  - Round=00 → 0x7F800000, Overflow=1, Inexact=1.
  - Round=01 → 0x7F7FFFFF, Overflow=1.
- **Specials:**
  - A=B=0x7F800000, Op=1 → 0x7FC00000, Invalid=1.
  - A=0x7F800000, B=0xFF800000, Op=0 → 0x7FC00000, Invalid=1.
  - A=0, B=0x7F800000, Op=0 → 0x7F800000, no flags.
- **Cancellation:** A=B=0x43700000, Op=1: Round=00 → 0x00000000; Round=11 → 0x80000000. Flags 0.
- **Handshake/reset:**
  - Start pulsed again while Busy → ignored, one Done only.
  - Reset asserted 3 cycles after Start → Busy, Done, Y, flags 0 immediately, no Done.
  - Next Start completes normally.
  - Repeat with EXP_W=5, MAN_W=10: 0x3C00 + 0x3C00 → 0x4000.
